// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: widths, reset/bubble encodings
// and the instruction-fetch state type.
package pipe_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 16;

    localparam logic [PC_W-1:0]   RESET_PC = 16'h0000;
    localparam logic [3:0]        HALT_OP  = 4'hF;
    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

    // Fetch sequencing: one idle cycle after reset, then fetch until a HALT
    // word is delivered; only a redirect restarts fetch from HALT.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage : pipe_pkg

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter with its next-PC mux (hold / +2 / redirect). The PC is
// always even; bit 0 of a redirect target is dropped.
module pc_reg #(
    parameter int              PC_W     = pipe_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = pipe_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] loadPc,
    input  logic            advance,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pcPlus2
);

    logic [PC_W-1:0] pcNext;

    // Sequential increment wraps modulo 2^PC_W (FFFE + 2 -> 0000).
    assign pcPlus2 = pc + PC_W'(2);

    // Next-PC select: redirect has priority over advance, otherwise hold.
    always_comb begin
        // NOTE: default first so every path assigns pcNext and no latch is inferred.
        pcNext = pc;
        if (load) begin
            pcNext = {loadPc[PC_W-1:1], 1'b0};
        end else if (advance) begin
            pcNext = pcPlus2;
        end
    end

    // PC register, asynchronously reset to the boot address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all clocked state so every
            // register samples pre-edge values regardless of block ordering.
            pc <= RESET_PC;
        end else begin
            pc <= pcNext;
        end
    end

endmodule : pc_reg

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the instruction memory handshake and feeds
// the IF/ID buffer combinationally (instruction, PC+2, load and flush strobes).
// Handles hazard stalls, redirects, memory wait states and HALT.
module if_fetch_stage #(
    parameter int                PC_W     = pipe_pkg::PC_W,
    parameter int                INST_W   = pipe_pkg::INST_W,
    parameter logic [PC_W-1:0]   RESET_PC = pipe_pkg::RESET_PC,
    parameter logic [3:0]        HALT_OP  = pipe_pkg::HALT_OP,
    parameter logic [INST_W-1:0] NOP_INST = pipe_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] instOut,
    output logic [PC_W-1:0]   pcAddOut,
    output logic              IFID_enable,
    output logic              flush,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    import pipe_pkg::*;

    fetch_state_e    state;
    fetch_state_e    stateNext;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pcPlus2;
    logic            accept;
    logic            isHalt;

    // An instruction is handed to IF/ID only when memory answers in FETCH
    // and neither a stall nor a redirect claims the cycle.
    assign accept = (state == FETCH) && imem_ready && !stall && !redirect;
    assign isHalt = (imem_rdata[INST_W-1 -: 4] == HALT_OP);

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect),
        .loadPc  (redirect_pc),
        .advance (accept),
        .pc      (pc),
        .pcPlus2 (pcPlus2)
    );

    // Fetch state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: redirect always restarts fetch; BOOT lasts one cycle;
    // a delivered HALT word stops fetch.
    always_comb begin
        stateNext = state;
        if (redirect) begin
            stateNext = FETCH;
        end else begin
            unique case (state)
                BOOT:    stateNext = FETCH;
                FETCH:   if (accept && isHalt) stateNext = HALT;
                HALT:    stateNext = HALT;
                default: stateNext = BOOT;
            endcase
        end
    end

    // IF/ID controls: redirect squashes, wait inserts a bubble, stall holds
    // the buffer (neither load nor flush), accept loads the memory word.
    always_comb begin
        IFID_enable = 1'b0;
        flush       = 1'b0;
        instOut     = NOP_INST;
        if (redirect) begin
            flush = 1'b1;
        end else begin
            unique case (state)
                FETCH: begin
                    if (stall) begin
                        flush = 1'b0;
                    end else if (imem_ready) begin
                        IFID_enable = 1'b1;
                        instOut     = imem_rdata;
                    end else begin
                        flush = 1'b1;
                    end
                end
                default: flush = 1'b1;
            endcase
        end
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign pcAddOut  = pcPlus2;
    assign halted    = (state == HALT);

    // Delivered-instruction counter; saturates rather than wrapping and is
    // cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 16'h0000;
        end else if (accept && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'h0001;
        end
    end

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected deliveries are queued as
// stimulus is driven and checked when IF/ID is loaded; control outputs are
// probed mid-cycle.
module tb_if_fetch_stage;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] inst;
        logic [15:0] pcAdd;
    } deliv_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] instOut;
    logic [15:0] pcAddOut;
    logic        IFID_enable;
    logic        flush;
    logic        halted;
    logic [15:0] fetch_count;

    int          checks = 0;
    int          errors = 0;
    deliv_t      sb[$];
    logic [15:0] expPc;
    logic [15:0] expCount;

    if_fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instOut     (instOut),
        .pcAddOut    (pcAddOut),
        .IFID_enable (IFID_enable),
        .flush       (flush),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model one delivery at the bench's own PC and advance that PC.
    task automatic expectAccept(input logic [15:0] inst);
        deliv_t d;
        d.addr  = expPc;
        d.inst  = inst;
        d.pcAdd = expPc + 16'd2;
        sb.push_back(d);
        expPc    = expPc + 16'd2;
        expCount = expCount + 16'd1;
    endtask

    // Scoreboard side: every IF/ID load must match the oldest queued delivery.
    always @(negedge clk) begin
        if (rst_n && IFID_enable) begin
            check("sb_underflow", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                deliv_t d;
                d = sb.pop_front();
                check("sb_addr",  32'(imem_addr), 32'(d.addr));
                check("sb_inst",  32'(instOut),   32'(d.inst));
                check("sb_pcadd", 32'(pcAddOut),  32'(d.pcAdd));
                check("sb_flush", 32'(flush),     32'd0);
            end
        end
    end

    initial begin
        expPc       = 16'h0000;
        expCount    = 16'h0000;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_ready  = 1'b1;
        imem_rdata  = 16'h1234;

        // Reset values.
        #3;
        check("rst_req",    32'(imem_req),    32'd0);
        check("rst_en",     32'(IFID_enable), 32'd0);
        check("rst_flush",  32'(flush),       32'd1);
        check("rst_halted", 32'(halted),      32'd0);
        check("rst_inst",   32'(instOut),     32'h0000);
        check("rst_pcadd",  32'(pcAddOut),    32'h0002);
        check("rst_count",  32'(fetch_count), 32'd0);

        // BOOT cycle.
        cyc();
        rst_n = 1'b1;
        #3;
        check("boot_flush", 32'(flush),    32'd1);
        check("boot_req",   32'(imem_req), 32'd0);

        // Zero-wait accepts at 0 and 2.
        cyc();
        expectAccept(16'h1234);
        #3;
        check("f0_req",  32'(imem_req),  32'd1);
        check("f0_addr", 32'(imem_addr), 32'h0000);
        cyc();
        expectAccept(16'h1234);

        // Two wait cycles at 0004.
        cyc();
        imem_ready = 1'b0;
        #3;
        check("w1_flush", 32'(flush),       32'd1);
        check("w1_en",    32'(IFID_enable), 32'd0);
        check("w1_inst",  32'(instOut),     32'h0000);
        check("w1_addr",  32'(imem_addr),   32'h0004);
        cyc();
        #3;
        check("w2_flush", 32'(flush),     32'd1);
        check("w2_addr",  32'(imem_addr), 32'h0004);
        check("w2_req",   32'(imem_req),  32'd1);
        cyc();
        imem_ready = 1'b1;
        expectAccept(16'h1234);

        // Stall for three cycles with memory ready.
        for (int i = 0; i < 3; i++) begin
            cyc();
            stall = 1'b1;
            #3;
            check("st_en",    32'(IFID_enable), 32'd0);
            check("st_flush", 32'(flush),       32'd0);
            check("st_addr",  32'(imem_addr),   32'(expPc));
            check("st_count", 32'(fetch_count), 32'(expCount));
        end

        // Redirect during stall; odd target bit is dropped.
        cyc();
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        #3;
        check("rd_flush", 32'(flush),       32'd1);
        check("rd_en",    32'(IFID_enable), 32'd0);
        cyc();
        stall    = 1'b0;
        redirect = 1'b0;
        expPc    = 16'h0040;
        #3;
        check("rd_addr", 32'(imem_addr), 32'h0040);
        expectAccept(16'h1234);

        // Redirect to 0010, then deliver a HALT word there.
        cyc();
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        cyc();
        redirect   = 1'b0;
        imem_rdata = 16'hF000;
        expPc      = 16'h0010;
        expectAccept(16'hF000);
        #3;
        check("hw_en", 32'(IFID_enable), 32'd1);
        cyc();
        imem_rdata = 16'h1234;
        #3;
        check("h_halted", 32'(halted),      32'd1);
        check("h_req",    32'(imem_req),    32'd0);
        check("h_flush",  32'(flush),       32'd1);
        check("h_addr",   32'(imem_addr),   32'h0012);
        check("h_count",  32'(fetch_count), 32'(expCount));
        cyc();
        #3;
        check("h_hold", 32'(halted), 32'd1);

        // Redirect out of HALT to 0020.
        cyc();
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        cyc();
        redirect = 1'b0;
        expPc    = 16'h0020;
        #3;
        check("hr_halted", 32'(halted),    32'd0);
        check("hr_addr",   32'(imem_addr), 32'h0020);
        expectAccept(16'h1234);

        // Wrap from FFFE to 0000.
        cyc();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        cyc();
        redirect = 1'b0;
        expPc    = 16'hFFFE;
        #3;
        check("wr_pcadd", 32'(pcAddOut), 32'h0000);
        expectAccept(16'h1234);
        cyc();
        #3;
        check("wr_addr", 32'(imem_addr), 32'h0000);
        expectAccept(16'h1234);

        // Wait at 0002, then asynchronous reset mid-cycle.
        cyc();
        imem_ready = 1'b0;
        #2;
        check("mw_addr", 32'(imem_addr), 32'h0002);
        check("mw_count", 32'(fetch_count), 32'(expCount));
        rst_n = 1'b0;
        #1;
        check("ar_req",   32'(imem_req),    32'd0);
        check("ar_addr",  32'(imem_addr),   32'h0000);
        check("ar_flush", 32'(flush),       32'd1);
        check("ar_count", 32'(fetch_count), 32'd0);

        #20;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_if_fetch_stage
